// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a single-outstanding-request
// memory port and a DEPTH-entry prefetch FIFO of {pc, instruction}.
// Optional macro FETCH_STATS_EN builds the delivered/flushed counters;
// when it is undefined, fetch_count and flush_count are tied to zero.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_KILL
    } state_e;

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q [DEPTH];
    logic [31:0]   pc_mem_d [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];

    logic          pop;
    logic          push;
    logic          room;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

    assign pop  = out_valid & out_ready;
    assign push = (state_q == ST_WAIT) & imem_ack & ~redirect_valid;

    // Next-state, request and FIFO update logic.
    // Occupancy is settled first (push/pop, then redirect flush) so the
    // request rule can look at the post-edge value in the same cycle.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        fetch_pc_d  = fetch_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push) begin
            pc_mem_d[wr_ptr_q]    = addr_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d              = wr_ptr_q + PW'(1);
            fetch_pc_d            = addr_q + 32'd4;
        end
        count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

        if (redirect_valid) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            wr_ptr_d   = wr_ptr_q;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end

        room = (count_d < DEPTH_C);

        case (state_q)
            ST_IDLE: begin
                if (!redirect_valid && room) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = ST_KILL;
                    end
                end else if (imem_ack) begin
                    if (room) begin
                        state_d = ST_WAIT;
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_d;
                    end else begin
                        state_d = ST_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            ST_KILL: begin
                if (imem_ack) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State, request and FIFO registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        drop;
    logic [CW-1:0] flushed;

    // A word is dropped when its ack lands in KILL or alongside a redirect;
    // the consumed head of a redirect cycle is delivered, not flushed.
    always_comb begin
        drop        = imem_ack & ((state_q == ST_KILL) |
                                  ((state_q == ST_WAIT) & redirect_valid));
        flushed     = redirect_valid ? (count_q - {{(CW-1){1'b0}}, pop}) : '0;
        fetch_cnt_d = fetch_cnt_q + {31'd0, pop};
        flush_cnt_d = flush_cnt_q + 32'(flushed) + {31'd0, drop};
    end

    // Statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, streaming, backpressure with wait
// states, redirect into KILL, redirect with same-cycle ack and pop, PC wrap
// and mid-transaction reset. Statistics expectations follow FETCH_STATS_EN.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic [31:0] fcnt2;
    logic [31:0] flcnt2;

    int          n_checks;
    int          n_errors;
    int          mem_waits;
    int          wcnt;
    logic        mem_en;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_ack       (ack2),
        .imem_rdata     (rdata2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .out_valid      (valid2),
        .out_ready      (1'b1),
        .out_pc         (pc2),
        .out_instr      (instr2),
        .fetch_count    (fcnt2),
        .flush_count    (flcnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory models: word returned equals its address; main port has
    // mem_waits wait states, wrap instance is always zero-wait.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        ack2       = 1'b0;
        rdata2     = '0;
        wcnt       = 0;
        forever begin
            @(posedge clk);
            #1;
            ack2   = req2;
            rdata2 = addr2;
            if (imem_req && mem_en) begin
                if (wcnt >= mem_waits) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr;
                    wcnt       = 0;
                end else begin
                    imem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wcnt     = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp(input logic [31:0] v);
`ifdef FETCH_STATS_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    int          acks;
    logic [31:0] last_ack_addr;
    logic        seen;

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b0;
        mem_en         = 1'b1;
        mem_waits      = 0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        // Reset state
        step();
        step();
        check_eq("rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr",  imem_addr, 32'h0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_pc",    out_pc, 32'h0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_fcnt",  fetch_count, 32'h0);
        check_eq("rst_flcnt", flush_count, 32'h0);
        check_eq("rst_addr2", addr2, 32'hFFFF_FFF8);

        // Zero-wait streaming, one instruction per cycle
        rst = 1'b1;
        step();
        check_eq("t1_req",   {31'd0, imem_req}, 32'd1);
        check_eq("t1_addr0", imem_addr, 32'h0);
        check_eq("t1_nvld",  {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
            check_eq("t1_pc",    out_pc, 32'(4 * i));
            check_eq("t1_instr", out_instr, 32'(4 * i));
            check_eq("t1_pc2",   pc2, 32'hFFFF_FFF8 + 32'(4 * i));
        end
        check_eq("t1_fcnt", fetch_count, stat_exp(32'd5));

        // Three wait states with no consumer: exactly DEPTH acks
        rst = 1'b0;
        step();
        mem_waits = 3;
        out_ready = 1'b0;
        step();
        rst  = 1'b1;
        acks = 0;
        last_ack_addr = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (imem_ack && imem_req) begin
                acks++;
                last_ack_addr = imem_addr;
            end
        end
        check_eq("t2_acks",    32'(acks), 32'd4);
        check_eq("t2_last",    last_ack_addr, 32'd12);
        check_eq("t2_req_off", {31'd0, imem_req}, 32'd0);
        check_eq("t2_head",    out_pc, 32'h0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t2_refill_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t2_refill_addr", imem_addr, 32'd16);
        check_eq("t2_head_pop",    out_pc, 32'd4);
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_ack && imem_req) begin
                acks++;
                last_ack_addr = imem_addr;
            end
        end
        check_eq("t2_one_ack",  32'(acks), 32'd1);
        check_eq("t2_ack_addr", last_ack_addr, 32'd16);
        check_eq("t2_req_idle", {31'd0, imem_req}, 32'd0);

        // Redirect while a request is outstanding without ack
        mem_en    = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("t3_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t3_addr", imem_addr, 32'd20);
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        check_eq("t3_flush_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t3_kill_req",    {31'd0, imem_req}, 32'd1);
        check_eq("t3_kill_addr",   imem_addr, 32'd20);
        redirect_valid = 1'b0;
        mem_en         = 1'b1;
        mem_waits      = 0;
        out_ready      = 1'b1;
        step();
        check_eq("t3_kill_ack", {31'd0, imem_ack}, 32'd1);
        step();
        check_eq("t3_idle_req",   {31'd0, imem_req}, 32'd0);
        check_eq("t3_idle_valid", {31'd0, out_valid}, 32'd0);
        step();
        check_eq("t3_new_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t3_new_addr", imem_addr, 32'h100);
        step();
        check_eq("t3_new_valid", {31'd0, out_valid}, 32'd1);
        check_eq("t3_new_pc",    out_pc, 32'h100);
        check_eq("t3_new_instr", out_instr, 32'h100);
        check_eq("t3_fcnt",      fetch_count, stat_exp(32'd2));
        check_eq("t3_flcnt",     flush_count, stat_exp(32'd4));

        // Redirect together with an ack and a head pop, three entries queued
        out_ready = 1'b0;
        step();
        check_eq("t4_head_a", out_pc, 32'h100);
        step();
        check_eq("t4_head_b", out_pc, 32'h100);
        check_eq("t4_ack",    {31'd0, imem_ack}, 32'd1);
        check_eq("t4_ackadr", imem_addr, 32'h10C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        check_eq("t4_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t4_req",   {31'd0, imem_req}, 32'd0);
        check_eq("t4_fcnt",  fetch_count, stat_exp(32'd3));
        check_eq("t4_flcnt", flush_count, stat_exp(32'd7));
        step();
        check_eq("t4_new_addr", imem_addr, 32'h200);
        mem_waits = 3;
        step();
        check_eq("t4_new_pc", out_pc, 32'h200);

        // Reset while in WAIT with two entries queued
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                step();
                if (imem_ack) seen = 1'b1;
            end
        end
        check_eq("t5_ack_seen", {31'd0, seen}, 32'd1);
        step();
        check_eq("t5_wait_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t5_wait_addr", imem_addr, 32'h208);
        check_eq("t5_head",      out_pc, 32'h200);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("t5_rst_req",   {31'd0, imem_req}, 32'd0);
        check_eq("t5_rst_addr",  imem_addr, 32'h0);
        mem_waits = 0;
        out_ready = 1'b1;
        step();
        rst = 1'b1;
        step();
        check_eq("t5_refetch_req",  {31'd0, imem_req}, 32'd1);
        check_eq("t5_refetch_addr", imem_addr, 32'h0);
        step();
        check_eq("t5_refetch_pc", out_pc, 32'h0);
        check_eq("t5_fcnt",       fetch_count, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
